// File: rtl/fetch_queue_pkg.sv
// Shared core constants for the fetch front end.
package fetch_queue_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; the head entry is visible on rdata while valid is high.
module sync_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * XLEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && (count_q != LW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    // Next-state for storage, pointers and occupancy; flush overrides everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign level = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues single-cycle-latency ROM reads and buffers results.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jump_en_i,
    input  logic [XLEN-1:0]           jump_addr_i,
    input  logic                      halt_i,
    output logic                      rom_req_o,
    output logic [XLEN-1:0]           rom_addr_o,
    input  logic                      rom_rvalid_i,
    input  logic [XLEN-1:0]           rom_rdata_i,
    output logic                      inst_valid_o,
    output logic [XLEN-1:0]           inst_o,
    output logic [XLEN-1:0]           inst_addr_o,
    input  logic                      inst_ready_i,
    output logic [$clog2(DEPTH):0]    level_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;

    logic [LW-1:0]     level;
    logic [LW:0]       occupancy;
    logic              issue, push, pop;
    logic              fifo_valid;
    logic [2*XLEN-1:0] fifo_rdata;

    // Reserve a slot for the in-flight response so a push never meets a full queue.
    assign occupancy = {1'b0, level} + (LW + 1)'(inflight_q);
    assign issue     = !rst && (state_q == ST_RUN) && !halt_i && !jump_en_i
                       && (occupancy < (LW + 1)'(DEPTH));
    assign push      = rom_rvalid_i && inflight_q && !jump_en_i;
    assign pop       = fifo_valid && inst_ready_i && !jump_en_i;

    // Next pc, in-flight flag and halt state; a jump wins over issue.
    always_comb begin
        state_d    = halt_i ? ST_HALT : ST_RUN;
        pc_d       = pc_q;
        inflight_d = issue;
        if (jump_en_i) begin
            pc_d = jump_addr_i & ~XLEN'(3);
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    // While a request is in flight, pc has already stepped past it, so its
    // address is pc-4 (a jump clears the in-flight flag before pc is reused).
    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jump_en_i),
        .push  (push),
        .wdata ({pc_q - XLEN'(4), rom_rdata_i}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .level (level)
    );

    assign rom_req_o    = issue;
    assign rom_addr_o   = pc_q;
    assign inst_valid_o = fifo_valid;
    assign inst_o       = fifo_valid ? fifo_rdata[XLEN-1:0]      : '0;
    assign inst_addr_o  = fifo_valid ? fifo_rdata[2*XLEN-1:XLEN] : '0;
    assign level_o      = level;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue with a one-cycle ROM returning addr+0x100.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        halt_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;
    logic [2:0]  level_o;

    int checks   = 0;
    int failures = 0;

    logic        prev_req;
    logic [31:0] prev_addr;

    fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .halt_i       (halt_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i),
        .level_o      (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        bit          halt;
        bit          jump;
        logic [31:0] jaddr;
        bit          ready;
        bit          inj;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_ia;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(bit rb, bit h, bit j, logic [31:0] ja, bit rdy, bit inj,
                                 bit er, logic [31:0] ea, bit ev, logic [31:0] eia,
                                 logic [2:0] el);
        vec_t v;
        v.rst_before = rb; v.halt = h; v.jump = j; v.jaddr = ja; v.ready = rdy; v.inj = inj;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_ia = eia; v.e_lvl = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        halt_i       = 1'b0;
        jump_en_i    = 1'b0;
        jump_addr_i  = 32'h0;
        inst_ready_i = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = 32'h0;
        #1;
        chk("rst_req",   {31'h0, rom_req_o},    32'h0);
        chk("rst_addr",  rom_addr_o,            32'h0);
        chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_inst",  inst_o,                32'h0);
        chk("rst_iaddr", inst_addr_o,           32'h0);
        chk("rst_level", {29'h0, level_o},      32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        prev_req = 1'b0;
    endtask

    // One cycle: drive inputs plus the ROM response to last cycle's request, check, clock.
    task automatic apply(input vec_t v, input string tag);
        if (v.rst_before) do_reset();
        halt_i       = v.halt;
        jump_en_i    = v.jump;
        jump_addr_i  = v.jaddr;
        inst_ready_i = v.ready;
        rom_rvalid_i = prev_req | v.inj;
        rom_rdata_i  = prev_req ? prev_addr + 32'h100 : 32'hBAD0_0000;
        #1;
        chk({tag, "_req"},   {31'h0, rom_req_o},    {31'h0, v.e_req});
        chk({tag, "_addr"},  rom_addr_o,            v.e_addr);
        chk({tag, "_valid"}, {31'h0, inst_valid_o}, {31'h0, v.e_valid});
        chk({tag, "_inst"},  inst_o,                v.e_valid ? v.e_ia + 32'h100 : 32'h0);
        chk({tag, "_iaddr"}, inst_addr_o,           v.e_valid ? v.e_ia : 32'h0);
        chk({tag, "_level"}, {29'h0, level_o},      {29'h0, v.e_lvl});
        prev_req  = rom_req_o;
        prev_addr = rom_addr_o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; halt_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0;
        inst_ready_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = 32'h0;
        prev_req = 1'b0; prev_addr = 32'h0;

        //          rb h j jaddr  rdy inj | req addr      v ia        lvl
        // streaming with ready=1, then halt with a response in flight and resume
        tbl.push_back(row(1, 0, 0, 32'h0,   1, 0, 1, 32'h00, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h04, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h08, 1, 32'h00, 3'd1));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h0C, 1, 32'h04, 3'd1));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h10, 1, 32'h08, 3'd1));
        tbl.push_back(row(0, 1, 0, 32'h0,   1, 0, 0, 32'h14, 1, 32'h0C, 3'd1));
        tbl.push_back(row(0, 1, 0, 32'h0,   1, 0, 0, 32'h14, 1, 32'h10, 3'd1));
        tbl.push_back(row(0, 1, 0, 32'h0,   1, 1, 0, 32'h14, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 0, 32'h14, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h14, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h18, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h1C, 1, 32'h14, 3'd1));
        // back-pressure fills the queue, then a jump flushes three entries
        tbl.push_back(row(1, 0, 0, 32'h0,   0, 0, 1, 32'h00, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   0, 0, 1, 32'h04, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   0, 0, 1, 32'h08, 1, 32'h00, 3'd1));
        tbl.push_back(row(0, 0, 0, 32'h0,   0, 0, 1, 32'h0C, 1, 32'h00, 3'd2));
        tbl.push_back(row(0, 0, 0, 32'h0,   0, 0, 0, 32'h10, 1, 32'h00, 3'd3));
        for (int i = 0; i < 5; i++)
            tbl.push_back(row(0, 0, 0, 32'h0, 0, i == 1, 0, 32'h10, 1, 32'h00, 3'd4));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 0, 32'h10, 1, 32'h00, 3'd4));
        tbl.push_back(row(0, 0, 1, 32'h203, 1, 0, 0, 32'h10, 1, 32'h04, 3'd3));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h200, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h204, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   1, 0, 1, 32'h208, 1, 32'h200, 3'd1));
        // lead-in for the reset-during-fetch sequence
        tbl.push_back(row(1, 0, 0, 32'h0,   0, 0, 1, 32'h00, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   0, 0, 1, 32'h04, 0, 32'h00, 3'd0));
        tbl.push_back(row(0, 0, 0, 32'h0,   0, 0, 1, 32'h08, 1, 32'h00, 3'd1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // Reset pulsed while the fetch of 0x8 is in flight: its response must be dropped.
        halt_i       = 1'b0;
        jump_en_i    = 1'b0;
        inst_ready_i = 1'b0;
        rom_rvalid_i = 1'b1;
        rom_rdata_i  = prev_addr + 32'h100;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_req",   {31'h0, rom_req_o},    32'h0);
        chk("midrst_addr",  rom_addr_o,            32'h0);
        chk("midrst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("midrst_level", {29'h0, level_o},      32'h0);
        rst = 1'b0;
        #1;
        chk("postrst_req",  {31'h0, rom_req_o},    32'h1);
        chk("postrst_addr", rom_addr_o,            32'h0);
        prev_req  = rom_req_o;
        prev_addr = rom_addr_o;
        @(posedge clk);
        #1;
        apply(row(0, 0, 0, 32'h0, 0, 0, 1, 32'h04, 0, 32'h00, 3'd0), "restart0");
        apply(row(0, 0, 0, 32'h0, 0, 0, 1, 32'h08, 1, 32'h00, 3'd1), "restart1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
